// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one ALU among NUM_REQ
//            requesters. Optional WAIT timeout enabled by ALU_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_error,
    output logic                      busy,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    output logic                      alu_start,
    input  logic [RES_W-1:0]          alu_result,
    input  logic                      alu_done
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W:0] c_NUM = (c_PTR_W+1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_ISSUE = 2'd1,
        c_WAIT  = 2'd2,
        c_RESP  = 2'd3
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
            $error("alu_arbiter: NUM_REQ or TIMEOUT out of range");
        end
    endgenerate

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [OP_W-1:0]      r_alu_op;
    logic                 r_alu_start;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [RES_W-1:0]     r_rsp_result;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_offset;
    logic [c_PTR_W:0]     w_sum;
    logic [c_PTR_W:0]     w_wrapped;
    logic [c_PTR_W-1:0]   w_winner;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [NUM_REQ-1:0]   w_owner_oh;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT > 255) ? 16 : 8;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_rsp_error;
    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

    // Rotate so bit 0 is the requester at the priority pointer.
    assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found  = 1'b1;
                w_offset = c_PTR_W'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_offset};
    assign w_wrapped  = (w_sum >= c_NUM) ? (w_sum - c_NUM) : w_sum;
    assign w_winner   = w_wrapped[c_PTR_W-1:0];
    assign w_next_ptr = (w_winner == c_LAST) ? '0 : (w_winner + c_PTR_W'(1));
    assign w_grant_oh = NUM_REQ'(1) << w_winner;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    assign req_ready  = (reset_n && (r_state == c_IDLE) && w_found) ? w_grant_oh : '0;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_start  = r_alu_start;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_start  <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_busy       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_rsp_error  <= 1'b0;
`endif
        end else begin
            r_alu_start <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_owner     <= w_winner;
                        r_ptr       <= w_next_ptr;
                        r_alu_a     <= req_a[w_winner*DATA_W +: DATA_W];
                        r_alu_b     <= req_b[w_winner*DATA_W +: DATA_W];
                        r_alu_op    <= req_op[w_winner*OP_W +: OP_W];
                        r_alu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // A done on the limit cycle still yields a normal response.
                    if (alu_done) begin
                        r_rsp_result <= alu_result;
                        r_rsp_valid  <= w_owner_oh;
`ifdef ALU_ARB_TIMEOUT_EN
                        r_rsp_error  <= 1'b0;
`endif
                        r_state      <= c_RESP;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (r_cnt == c_LIMIT) begin
                        r_rsp_result <= '0;
                        r_rsp_valid  <= w_owner_oh;
                        r_rsp_error  <= 1'b1;
                        r_state      <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                c_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Testbench for alu_arbiter: vector table, corner-case sequences and a
// randomized run against a cycle-level reference model.
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int RES_W   = 16;
    localparam int TIMEOUT = 255;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [RES_W-1:0]          rsp_result;
    logic                      rsp_error;
    logic                      busy;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_op;
    logic                      alu_start;
    logic [RES_W-1:0]          alu_result = '0;
    logic                      alu_done   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .OP_W    (OP_W),
        .RES_W   (RES_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return {8'h00, a} * {8'h00, b};
            3'd3:    return {8'h00, a & b};
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ALU stand-in: done arrives L cycles after the start cycle; lat 0 never answers.
    int alu_lat   = 0;
    int alu_rem   = 0;
    int spur_req  = 0;
    int spur_seen = 0;
    always @(negedge clk) begin
        alu_done = 1'b0;
        if (alu_start === 1'b1) begin
            alu_rem = alu_lat;
        end else if (alu_rem > 0) begin
            alu_rem--;
            if (alu_rem == 0) begin
                alu_done   = 1'b1;
                alu_result = alu_f(alu_a, alu_b, alu_op);
            end
        end
        if (spur_req != spur_seen) begin
            spur_seen  = spur_req;
            alu_done   = 1'b1;
            alu_result = 16'hDEAD;
        end
    end

    typedef struct {
        logic [3:0]  rv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        int          lat;
        logic [3:0]  exp_g;
        logic [15:0] exp_r;
    } vec_t;

    vec_t tbl[8];

    task automatic drive_req(input logic [3:0] rv, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op, input int win);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*DATA_W +: DATA_W] = (i == win) ? a : (a ^ 8'h5A);
            req_b[i*DATA_W +: DATA_W] = (i == win) ? b : (b ^ 8'hA5);
            req_op[i*OP_W +: OP_W]    = (i == win) ? op : (op ^ 3'h5);
        end
        req_valid = rv;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_txn(input logic [3:0] rv, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input int lat, input logic [3:0] exp_g,
                           input logic [15:0] exp_r, input bit spur_issue);
        int w;
        w = -1;
        for (int i = 0; i < NUM_REQ; i++) if (exp_g[i]) w = i;
        @(posedge clk); #1;
        drive_req(rv, a, b, op, w);
        alu_lat = lat;
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_g));
        chk("busy_idle", 32'(busy), 32'(0));
        if (exp_g == 4'b0000) begin
            @(posedge clk); #1;
            req_valid = '0;
        end else begin
            @(posedge clk); #1;
            req_valid = '0;
            if (spur_issue) spur_req++;
            #1;
            chk("alu_start", 32'(alu_start), 32'(1));
            chk("alu_a", 32'(alu_a), 32'(a));
            chk("alu_b", 32'(alu_b), 32'(b));
            chk("alu_op", 32'(alu_op), 32'(op));
            chk("busy_issue", 32'(busy), 32'(1));
            for (int c = 2; c <= 2 + lat; c++) begin
                @(posedge clk); #2;
                chk("rsp_valid", 32'(rsp_valid), (c == 2 + lat) ? 32'(exp_g) : 32'(0));
                if (c == 2 + lat) begin
                    chk("rsp_result", 32'(rsp_result), 32'(exp_r));
                    chk("rsp_error", 32'(rsp_error), 32'(0));
                end else begin
                    chk("alu_start_once", 32'(alu_start), 32'(0));
                end
            end
        end
    endtask

    task automatic stall_test();
        int  waited;
        bit  seen;
        waited = 0;
        seen   = 1'b0;
        @(posedge clk); #1;
        drive_req(4'b0001, 8'h12, 8'h34, 3'd0, 0);
        alu_lat = 0;
        #1;
        chk("stall_ready", 32'(req_ready), 32'(4'b0001));
        @(posedge clk); #1;
        req_valid = '0;
`ifdef ALU_ARB_TIMEOUT_EN
        while (rsp_valid == '0 && waited < TIMEOUT + 20) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("timeout_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
        chk("timeout_rsp_error", 32'(rsp_error), 32'(1));
        chk("timeout_rsp_result", 32'(rsp_result), 32'(0));
`else
        repeat (300) begin
            @(posedge clk); #2;
            if (rsp_valid != '0) seen = 1'b1;
            waited++;
        end
        chk("hang_busy", 32'(busy), 32'(1));
        chk("hang_no_rsp", 32'(seen), 32'(0));
`endif
        do_reset();
    endtask

    task automatic random_phase(input int nops);
        bit          pend[NUM_REQ];
        logic [7:0]  pa[NUM_REQ];
        logic [7:0]  pb[NUM_REQ];
        logic [2:0]  po[NUM_REQ];
        logic [3:0]  rv;
        logic [3:0]  exp_ready;
        logic [3:0]  rsp_exp;
        logic [15:0] res_exp;
        int mptr, cyc, free_at, grant_at, start_at, rsp_at, ops, w, lat, j;
        mptr = 0; cyc = 0; free_at = 0; grant_at = -10; start_at = -10; rsp_at = -10;
        ops = 0; lat = 1; rsp_exp = '0; res_exp = '0; rv = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0;
        end
        while ((ops < nops || cyc <= rsp_at) && cyc < 20000) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ops < nops && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = 8'($urandom);
                    pb[i]   = 8'($urandom);
                    po[i]   = 3'($urandom);
                end
                rv[i] = pend[i];
                req_a[i*DATA_W +: DATA_W] = pend[i] ? pa[i] : 8'($urandom);
                req_b[i*DATA_W +: DATA_W] = pend[i] ? pb[i] : 8'($urandom);
                req_op[i*OP_W +: OP_W]    = pend[i] ? po[i] : 3'($urandom);
            end
            req_valid = rv;
            exp_ready = '0;
            w = -1;
            if (cyc >= free_at) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (mptr + k) % NUM_REQ;
                    if (w < 0 && pend[j]) w = j;
                end
            end
            if (w >= 0) begin
                lat = $urandom_range(1, 5);
                alu_lat = lat;
                exp_ready[w] = 1'b1;
            end
            #1;
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_rsp_valid", 32'(rsp_valid), (cyc == rsp_at) ? 32'(rsp_exp) : 32'(0));
            if (cyc == rsp_at) begin
                chk("rnd_rsp_result", 32'(rsp_result), 32'(res_exp));
                chk("rnd_rsp_error", 32'(rsp_error), 32'(0));
            end
            chk("rnd_alu_start", 32'(alu_start), 32'(cyc == start_at));
            chk("rnd_busy", 32'(busy), 32'(cyc > grant_at && cyc < free_at));
            if (w >= 0) begin
                grant_at   = cyc;
                start_at   = cyc + 1;
                rsp_at     = cyc + 2 + lat;
                free_at    = cyc + 3 + lat;
                rsp_exp    = '0;
                rsp_exp[w] = 1'b1;
                res_exp    = alu_f(pa[w], pb[w], po[w]);
                pend[w]    = 1'b0;
                mptr       = (w + 1) % NUM_REQ;
                ops++;
            end
            cyc++;
        end
        req_valid = '0;
        chk("rnd_within_budget", 32'(cyc < 20000), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        tbl[0] = '{4'b0001, 8'h05, 8'h03, 3'd0, 2, 4'b0001, 16'h0008};
        tbl[1] = '{4'b1111, 8'h10, 8'h04, 3'd1, 3, 4'b0010, 16'h000C};
        tbl[2] = '{4'b1001, 8'h03, 8'h07, 3'd2, 1, 4'b1000, 16'h0015};
        tbl[3] = '{4'b1001, 8'hF0, 8'h3C, 3'd3, 2, 4'b0001, 16'h0030};
        tbl[4] = '{4'b1001, 8'h80, 8'h80, 3'd0, 4, 4'b1000, 16'h0100};
        tbl[5] = '{4'b0110, 8'hAA, 8'h55, 3'd4, 1, 4'b0010, 16'h00FF};
        tbl[6] = '{4'b0100, 8'hFF, 8'hFF, 3'd0, 1, 4'b0100, 16'h01FE};
        tbl[7] = '{4'b0000, 8'h00, 8'h00, 3'd0, 1, 4'b0000, 16'h0000};

        do_reset();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_result", 32'(rsp_result), 32'(0));
        chk("rst_rsp_error", 32'(rsp_error), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_alu_b", 32'(alu_b), 32'(0));
        chk("rst_alu_op", 32'(alu_op), 32'(0));
        chk("rst_alu_start", 32'(alu_start), 32'(0));

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].rv, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].lat,
                    tbl[i].exp_g, tbl[i].exp_r, 1'b0);

        // Spurious done in IDLE, then in ISSUE of the next operation.
        @(posedge clk); #1;
        spur_req++;
        repeat (3) begin
            @(posedge clk); #2;
            chk("spur_idle_rsp", 32'(rsp_valid), 32'(0));
            chk("spur_idle_busy", 32'(busy), 32'(0));
        end
        run_txn(4'b0001, 8'h09, 8'h0A, 3'd1, 3, 4'b0001, 16'hFFFF, 1'b1);

        // Reset during WAIT discards the operation and clears the pointer.
        @(posedge clk); #1;
        drive_req(4'b0010, 8'h11, 8'h22, 3'd0, 1);
        alu_lat = 6;
        #1;
        chk("mid_ready", 32'(req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_rsp", 32'(rsp_valid), 32'(0));
        chk("mid_rst_alu_a", 32'(alu_a), 32'(0));
        repeat (8) begin
            @(posedge clk); #2;
            chk("late_done_rsp", 32'(rsp_valid), 32'(0));
            chk("late_done_busy", 32'(busy), 32'(0));
        end
        run_txn(4'b1111, 8'h21, 8'h02, 3'd2, 1, 4'b0001, 16'h0042, 1'b0);

        stall_test();

        random_phase(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one `alu` instance among `NUM_REQ` requesters. It grants one request at a time and latches that request's operands and opcode. It then drives the ALU `start`/`done` handshake and returns the result to the granted requester as a one-cycle response. It sits directly in front of the `alu` datapath, and its ALU-side ports connect one-to-one to `A`, `B`, `op`, `start`, `result` and `done`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: ALU operand width.
- `OP_W`, 3: ALU opcode width.
- `RES_W`, 16: ALU result width.
- `TIMEOUT`, 255: WAIT-state cycle limit, used only with `ALU_ARB_TIMEOUT_EN`.
- Clocking and reset (already decided): one clock; reset is synchronous and active-low.
- `clk` input 1: sole clock; all state changes on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester request. Held high until accepted.
- `req_ready` output NUM_REQ: one-hot acceptance strobe. A request transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `req_a` input NUM_REQ*DATA_W: packed A operands; requester i uses slice [i*DATA_W +: DATA_W].
- `req_b` input NUM_REQ*DATA_W: packed B operands, same slicing as `req_a`.
- `req_op` input NUM_REQ*OP_W: packed opcodes.
- `rsp_valid` output NUM_REQ: one-hot, one-cycle response strobe to the owner.
- `rsp_result` output RES_W: result, valid while any `rsp_valid` bit is high.
- `rsp_error` output 1: timeout flag, qualified by `rsp_valid`.
- `busy` output 1: high in every state except IDLE.
- `alu_a`, `alu_b` output DATA_W: latched operands to the ALU.
- `alu_op` output OP_W: latched opcode.
- `alu_start` output 1: one-cycle start pulse.
- `alu_result` input RES_W: ALU result.
- `alu_done` input 1: ALU completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, some `req_valid` high:
  - pick the winner: first set bit scanning upward from priority pointer `ptr`, with wrap-around;
  - assert `req_ready[winner]` combinationally in this cycle;
  - latch `alu_a`, `alu_b`, `alu_op` and `owner`;
  - set `ptr` to (winner+1) mod NUM_REQ;
  - go to ISSUE.
- IDLE, no request: `req_ready` stays 0 and the FSM stays in IDLE.
- ISSUE: `alu_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `alu_done`=1, register `alu_result` into `rsp_result` and go to RESP. Otherwise remain in WAIT.
- RESP: `rsp_valid[owner]`=1 for one cycle, then go to IDLE. No request is accepted in RESP.
- `alu_done` is sampled only in WAIT. Any `alu_done` seen in IDLE, ISSUE or RESP is ignored.
- `req_valid` changes outside IDLE have no effect. A dropped request loses its turn; no state is kept for it.
- `alu_a`, `alu_b` and `alu_op` hold their values from grant until the next grant.
- Reset values: `ptr`=0, FSM=IDLE. All outputs are 0: `req_ready`, `rsp_valid`, `rsp_result`, `rsp_error`, `busy`, `alu_*`.
- Reset mid-operation returns the block to IDLE on the next edge. The in-flight operation is discarded and no response is issued. A late `alu_done` after reset is ignored because it arrives in IDLE.

## Timing
- Cycle 0: accept (`req_ready` high) in IDLE.
- Cycle 1: `alu_start` in ISSUE.
- Cycle 1+L: `alu_done`, where L ≥ 1 is the ALU latency.
- Cycle 2+L: `rsp_valid`.
- Next accept is possible no earlier than cycle 3+L, giving throughput of one operation per L+3 cycles.
- `req_ready` is combinational from `req_valid` and `ptr`, and only in IDLE. All other outputs are registered.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - an 8..16-bit counter clears on entry to WAIT and increments on every WAIT cycle without `alu_done`;
  - when the counter reaches `TIMEOUT`, the FSM goes to RESP with `rsp_error`=1 and `rsp_result`=0;
  - `alu_done` in the same cycle as the limit takes priority, giving a normal response with `rsp_error`=0.
- Not defined: no counter. WAIT lasts until `alu_done`, and `rsp_error` is tied to 0.

## Test plan
- Single request: after reset, `req_valid`=0001, A=8'h05, B=8'h03, op=add; ALU returns 16'h0008 with L=2 → `req_ready`=0001 at cycle 0, `alu_start` at 1, `rsp_valid`=0001 with `rsp_result`=16'h0008 at cycle 4.
- Round-robin: all four `req_valid` held high continuously → grants follow 0,1,2,3,0. Each requester gets exactly one response per four operations.
- Pointer wrap: after a grant to requester 3, `req_valid`=1001 → requester 0 is granted next; then, with 1001 still held, requester 3.
- Spurious done: `alu_done` pulsed in IDLE and in ISSUE → ignored, with no `rsp_valid` until the real done in WAIT.
- Reset mid-WAIT: `reset_n`=0 for one cycle during WAIT → FSM returns to IDLE and `ptr`=0. No `rsp_valid` is produced, and a later `alu_done` is ignored.
- Timeout (`ALU_ARB_TIMEOUT_EN`, TIMEOUT=10): `alu_done` held low → `rsp_valid` with `rsp_error`=1 and `rsp_result`=0. Without the macro, `busy` stays high indefinitely.
